// File: rtl/mem_arbiter_if.sv
// Bundle of both cache ports plus the shared memory port.
// slave is the arbiter's view; master is the caches-and-memory side.
interface mem_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             p0_read_req;
    logic [WIDTH-1:0] p0_read_addr;
    logic [WIDTH-1:0] p0_read_data;
    logic             p0_read_ack;
    logic             p0_write_req;
    logic [WIDTH-1:0] p0_write_addr;
    logic [WIDTH-1:0] p0_write_data;
    logic             p0_write_ack;

    logic             p1_read_req;
    logic [WIDTH-1:0] p1_read_addr;
    logic [WIDTH-1:0] p1_read_data;
    logic             p1_read_ack;
    logic             p1_write_req;
    logic [WIDTH-1:0] p1_write_addr;
    logic [WIDTH-1:0] p1_write_data;
    logic             p1_write_ack;

    logic             mem_enable;
    logic             mem_rw;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_data_in;
    logic [3:0]       mem_byte_enable;
    logic [WIDTH-1:0] mem_data_out;
    logic             mem_ack;

    modport slave (
        input  p0_read_req, p0_read_addr,
        input  p0_write_req, p0_write_addr, p0_write_data,
        input  p1_read_req, p1_read_addr,
        input  p1_write_req, p1_write_addr, p1_write_data,
        output p0_read_data, p0_read_ack, p0_write_ack,
        output p1_read_data, p1_read_ack, p1_write_ack,
        output mem_enable, mem_rw, mem_addr,
        output mem_data_in, mem_byte_enable,
        input  mem_data_out, mem_ack
    );

    modport master (
        output p0_read_req, p0_read_addr,
        output p0_write_req, p0_write_addr, p0_write_data,
        output p1_read_req, p1_read_addr,
        output p1_write_req, p1_write_addr, p1_write_data,
        input  p0_read_data, p0_read_ack, p0_write_ack,
        input  p1_read_data, p1_read_ack, p1_write_ack,
        input  mem_enable, mem_rw, mem_addr,
        input  mem_data_in, mem_byte_enable,
        output mem_data_out, mem_ack
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin, write-before-read arbiter sharing one async memory
// between two cache ports via a four-phase handshake sequencer.
module mem_arbiter #(
    parameter int WIDTH = 32
) (
    input logic         clk,
    input logic         reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESPOND,
        RELEASE
    } state_t;

    state_t state;

    logic gnt;
    logic wr;
    logic last;
    logic abort;

    logic [1:0] rd_req;
    logic [1:0] wr_req;
    logic [1:0][WIDTH-1:0] rd_addr;
    logic [1:0][WIDTH-1:0] wr_addr;
    logic [1:0][WIDTH-1:0] wr_data;

    logic [1:0][WIDTH-1:0] rd_data;
    logic [1:0] rd_ack;
    logic [1:0] wr_ack;
    logic             mem_enable;
    logic             mem_rw;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_data_in;

    logic req0;
    logic req1;
    logic pick;
    logic greq;

    assign rd_req  = {bus.p1_read_req, bus.p0_read_req};
    assign wr_req  = {bus.p1_write_req, bus.p0_write_req};
    assign rd_addr = {bus.p1_read_addr, bus.p0_read_addr};
    assign wr_addr = {bus.p1_write_addr, bus.p0_write_addr};
    assign wr_data = {bus.p1_write_data, bus.p0_write_data};

    assign bus.p0_read_data  = rd_data[0];
    assign bus.p1_read_data  = rd_data[1];
    assign bus.p0_read_ack   = rd_ack[0];
    assign bus.p1_read_ack   = rd_ack[1];
    assign bus.p0_write_ack  = wr_ack[0];
    assign bus.p1_write_ack  = wr_ack[1];
    assign bus.mem_enable    = mem_enable;
    assign bus.mem_rw        = mem_rw;
    assign bus.mem_addr      = mem_addr;
    assign bus.mem_data_in   = mem_data_in;
    assign bus.mem_byte_enable = {4{mem_enable}};

    // On a conflict the port that did not win last time goes next.
    always_comb begin
        req0 = rd_req[0] | wr_req[0];
        req1 = rd_req[1] | wr_req[1];
        pick = (req0 && req1) ? ~last : req1;
        greq = wr ? wr_req[gnt] : rd_req[gnt];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            gnt         <= 1'b0;
            wr          <= 1'b0;
            last        <= 1'b1;
            abort       <= 1'b0;
            rd_data     <= '0;
            rd_ack      <= '0;
            wr_ack      <= '0;
            mem_enable  <= 1'b0;
            mem_rw      <= 1'b0;
            mem_addr    <= '0;
            mem_data_in <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        gnt        <= pick;
                        last       <= pick;
                        wr         <= wr_req[pick];
                        abort      <= 1'b0;
                        mem_rw     <= ~wr_req[pick];
                        mem_enable <= 1'b1;
                        if (wr_req[pick]) begin
                            mem_addr    <= wr_addr[pick];
                            mem_data_in <= wr_data[pick];
                        end else begin
                            mem_addr <= rd_addr[pick];
                        end
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    // A request that dropped even briefly is an abort.
                    if (bus.mem_ack) begin
                        if (greq && !abort) begin
                            if (wr) begin
                                wr_ack[gnt] <= 1'b1;
                            end else begin
                                rd_ack[gnt]  <= 1'b1;
                                rd_data[gnt] <= bus.mem_data_out;
                            end
                            state <= RESPOND;
                        end else begin
                            mem_enable <= 1'b0;
                            state      <= RELEASE;
                        end
                    end else if (!greq) begin
                        abort <= 1'b1;
                    end
                end
                RESPOND: begin
                    if (!greq) begin
                        rd_ack     <= '0;
                        wr_ack     <= '0;
                        mem_enable <= 1'b0;
                        state      <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!bus.mem_ack) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule
